// File: rtl/izh_sched_pkg.sv
// Shared types and constants for the Izhikevich time-multiplexed scheduler:
// the sweep FSM state encoding and the default membrane reset voltage.
package izh_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STEP,
      WB,
      DONE
   } sched_state_t;

   // -65.0 in Q8 fixed point, 24-bit word
   localparam logic [23:0] V_RST_DEFAULT = 24'hFFBF00;

endpackage

// File: rtl/izhikevich_tdm_scheduler_if.sv
// Bundle of the scheduler's control, preload, input-current and core-facing signals.
// master = the scheduler, slave = the surrounding system (core, current source, host).
interface izhikevich_tdm_scheduler_if #(
   parameter int N  = 24,
   parameter int AW = 3
);
   logic          start;
   logic          busy;
   logic          done;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [N-1:0]  cfg_v;
   logic [N-1:0]  cfg_w;
   logic [AW-1:0] i_addr;
   logic [N-1:0]  i_data;
   logic          core_rst;
   logic          core_apply;
   logic [N-1:0]  core_v_init;
   logic [N-1:0]  core_w_init;
   logic [N-1:0]  core_i;
   logic [N-1:0]  core_voltage;
   logic [N-1:0]  core_w;
   logic          core_is_spiking;
   logic          spike_valid;
   logic [AW-1:0] spike_id;

   modport master (
      input  start, cfg_we, cfg_addr, cfg_v, cfg_w, i_data,
             core_voltage, core_w, core_is_spiking,
      output busy, done, i_addr, core_rst, core_apply,
             core_v_init, core_w_init, core_i, spike_valid, spike_id
   );

   modport slave (
      output start, cfg_we, cfg_addr, cfg_v, cfg_w, i_data,
             core_voltage, core_w, core_is_spiking,
      input  busy, done, i_addr, core_rst, core_apply,
             core_v_init, core_w_init, core_i, spike_valid, spike_id
   );
endinterface

// File: rtl/izh_state_ram.sv
// Per-neuron v/w state store: one write port, asynchronous read,
// synchronous reset that restores every entry to (V_RST, 0).
module izh_state_ram #(
   parameter int             N     = 24,
   parameter int             DEPTH = 8,
   parameter int             AW    = $clog2(DEPTH),
   parameter logic [N-1:0]   V_RST = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [N-1:0]  wv,
   input  logic [N-1:0]  ww,
   input  logic [AW-1:0] raddr,
   output logic [N-1:0]  rv,
   output logic [N-1:0]  rw
);
   logic [N-1:0] v_mem [DEPTH];
   logic [N-1:0] w_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            v_mem[i] <= V_RST;
            w_mem[i] <= '0;
         end
      end else if (we) begin
         v_mem[waddr] <= wv;
         w_mem[waddr] <= ww;
      end
   end

   assign rv = v_mem[raddr];
   assign rw = w_mem[raddr];
endmodule

// File: rtl/izhikevich_tdm_scheduler.sv
// Sweeps NEURONS neuron states through one shared Izhikevich core (LOAD/STEP/WB per neuron).
// Optional IZH_SCHED_SPIKE_COUNT_EN adds a saturating 16-bit spike counter port.
module izhikevich_tdm_scheduler
   import izh_sched_pkg::*;
#(
   parameter int           N       = 24,
   parameter int           Q       = 8,
   parameter int           NEURONS = 8,
   parameter logic [N-1:0] V_RST   = V_RST_DEFAULT
) (
   input  logic clk,
   input  logic rst,
`ifdef IZH_SCHED_SPIKE_COUNT_EN
   output logic [15:0] spike_count,
`endif
   izhikevich_tdm_scheduler_if.master bus
);
   localparam int            AW   = $clog2(NEURONS);
   localparam logic [AW-1:0] LAST = AW'(NEURONS - 1);

   generate
      if (Q >= N || NEURONS < 2 || (NEURONS & (NEURONS - 1)) != 0) begin : g_param_check
         $error("izhikevich_tdm_scheduler: invalid N/Q/NEURONS parameters");
      end
   endgenerate

   sched_state_t  state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] i_addr_q;
   logic [AW-1:0] spike_id_q;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [N-1:0]  ram_wv, ram_ww;
   logic [N-1:0]  rd_v, rd_w;

   izh_state_ram #(
      .N     (N),
      .DEPTH (NEURONS),
      .AW    (AW),
      .V_RST (V_RST)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wv    (ram_wv),
      .ww    (ram_ww),
      .raddr (idx_q),
      .rv    (rd_v),
      .rw    (rd_w)
   );

   // i_addr and spike_id hold their last driven value between strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         i_addr_q   <= '0;
         spike_id_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         i_addr_q   <= bus.i_addr;
         spike_id_q <= bus.spike_id;
      end
   end

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      bus.busy         = (state_q != IDLE);
      bus.done         = 1'b0;
      bus.core_rst     = 1'b0;
      bus.core_apply   = 1'b0;
      bus.core_v_init  = rd_v;
      bus.core_w_init  = rd_w;
      bus.core_i       = bus.i_data;
      bus.i_addr       = i_addr_q;
      bus.spike_valid  = 1'b0;
      bus.spike_id     = spike_id_q;
      ram_we           = 1'b0;
      ram_waddr        = bus.cfg_addr;
      ram_wv           = bus.cfg_v;
      ram_ww           = bus.cfg_w;
      case (state_q)
         IDLE: begin
            // preload write lands on the same edge that launches the sweep
            ram_we = bus.cfg_we;
            if (bus.start) begin
               idx_d   = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            bus.core_rst = 1'b1;
            bus.i_addr   = idx_q;
            state_d      = STEP;
         end
         STEP: begin
            bus.core_apply = 1'b1;
            state_d        = WB;
         end
         WB: begin
            ram_we    = 1'b1;
            ram_waddr = idx_q;
            ram_wv    = bus.core_voltage;
            ram_ww    = bus.core_w;
            if (bus.core_is_spiking) begin
               bus.spike_valid = 1'b1;
               bus.spike_id    = idx_q;
            end
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = LOAD;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef IZH_SCHED_SPIKE_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         spike_count <= '0;
      end else if (bus.spike_valid && spike_count != 16'hFFFF) begin
         spike_count <= spike_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_izhikevich_tdm_scheduler.sv
// Directed bench for izhikevich_tdm_scheduler with NEURONS=4 and a small behavioural core
// (v_th=30.0, c=-65.0, d=8.0; below threshold v <= v + i). Build with IZH_SCHED_SPIKE_COUNT_EN for the counter checks.
module tb_izhikevich_tdm_scheduler;
   localparam logic [23:0] V_TH   = 24'h001E00;
   localparam logic [23:0] C_RST  = 24'hFFBF00;
   localparam logic [23:0] D_INC  = 24'h000800;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   izhikevich_tdm_scheduler_if #(.N(24), .AW(2)) bus ();

`ifdef IZH_SCHED_SPIKE_COUNT_EN
   logic [15:0] spike_count;
`endif

   izhikevich_tdm_scheduler #(
      .N       (24),
      .Q       (8),
      .NEURONS (4),
      .V_RST   (24'hFFBF00)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef IZH_SCHED_SPIKE_COUNT_EN
      .spike_count (spike_count),
`endif
      .bus         (bus)
   );

   always #5 clk = ~clk;

   logic [23:0] cur [4];
   logic [23:0] cv   = '0;
   logic [23:0] cw   = '0;
   logic        cspk = 1'b0;

   // current source answers one cycle after i_addr
   always @(posedge clk) bus.i_data <= cur[bus.i_addr];

   // stand-in for the shared core
   always @(posedge clk) begin
      if (bus.core_rst) begin
         cv   <= bus.core_v_init;
         cw   <= bus.core_w_init;
         cspk <= 1'b0;
      end else if (bus.core_apply) begin
         if ($signed(cv) > $signed(V_TH)) begin
            cv   <= C_RST;
            cw   <= cw + D_INC;
            cspk <= 1'b1;
         end else begin
            cv   <= cv + bus.core_i;
            cspk <= 1'b0;
         end
      end
   end

   assign bus.core_voltage    = cv;
   assign bus.core_w          = cw;
   assign bus.core_is_spiking = cspk;

   int         busy_cnt, done_cnt, done_at, spike_cnt, overlap_cnt, load_n;
   logic [1:0] last_spike_id;
   logic [7:0] load_seq;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic we, input logic [1:0] a,
                                input logic [23:0] v, input logic [23:0] w);
      bus.start    = s;
      bus.cfg_we   = we;
      bus.cfg_addr = a;
      bus.cfg_v    = v;
      bus.cfg_w    = w;
   endtask

   task automatic setCur(input logic [23:0] c0, input logic [23:0] c1,
                         input logic [23:0] c2, input logic [23:0] c3);
      cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
   endtask

   // start (optionally with a same-cycle preload) and observe 40 cycles;
   // at cycle inj_at a start plus a write of 0x123400 to neuron 0 is injected
   task automatic runSweep(input logic we0, input logic [1:0] a0, input logic [23:0] v0,
                           input logic [23:0] w0, input int inj_at);
      busy_cnt = 0; done_cnt = 0; done_at = 0; spike_cnt = 0;
      overlap_cnt = 0; load_n = 0; load_seq = '0; last_spike_id = '0;
      @(negedge clk);
      applyStimulus(1'b1, we0, a0, v0, w0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_cnt == 1) done_at = k;
         end
         if (bus.core_rst && bus.core_apply) overlap_cnt++;
         if (bus.core_rst) begin
            load_n++;
            load_seq = {load_seq[5:0], bus.i_addr};
         end
         if (bus.spike_valid) begin
            spike_cnt++;
            last_spike_id = bus.spike_id;
         end
         if (k == inj_at) applyStimulus(1'b1, 1'b1, 2'd0, 24'h123400, 24'h0);
         else             applyStimulus(1'b0, 1'b0, 2'd0, 24'h0, 24'h0);
      end
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 2'd0, 24'h0, 24'h0);
      setCur(24'h0, 24'h0, 24'h0, 24'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_done", 32'(bus.done), 32'd0);
      checkOutput("rst_spike_valid", 32'(bus.spike_valid), 32'd0);
      checkOutput("rst_core_rst", 32'(bus.core_rst), 32'd0);
      checkOutput("rst_core_apply", 32'(bus.core_apply), 32'd0);
      checkOutput("rst_i_addr", 32'(bus.i_addr), 32'd0);
      checkOutput("rst_spike_id", 32'(bus.spike_id), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rst_v%0d", i), 32'(dut.u_ram.v_mem[i]), 32'h00FFBF00);
         checkOutput($sformatf("rst_w%0d", i), 32'(dut.u_ram.w_mem[i]), 32'h0);
      end
`ifdef IZH_SCHED_SPIKE_COUNT_EN
      checkOutput("rst_spike_count", 32'(spike_count), 32'd0);
`endif
      rst = 1'b0;

      // plain sweep: v += i for every neuron
      setCur(24'h000100, 24'h000200, 24'h000300, 24'h000A00);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 0);
      checkOutput("s1_busy_cycles", 32'(busy_cnt), 32'd13);
      checkOutput("s1_done_count", 32'(done_cnt), 32'd1);
      checkOutput("s1_done_at", 32'(done_at), 32'd13);
      checkOutput("s1_load_count", 32'(load_n), 32'd4);
      checkOutput("s1_i_addr_seq", 32'(load_seq), 32'h1B);
      checkOutput("s1_rst_apply_overlap", 32'(overlap_cnt), 32'd0);
      checkOutput("s1_spikes", 32'(spike_cnt), 32'd0);
      checkOutput("s1_v0", 32'(dut.u_ram.v_mem[0]), 32'h00FFC000);
      checkOutput("s1_v1", 32'(dut.u_ram.v_mem[1]), 32'h00FFC100);
      checkOutput("s1_v2", 32'(dut.u_ram.v_mem[2]), 32'h00FFC200);
      checkOutput("s1_v3", 32'(dut.u_ram.v_mem[3]), 32'h00FFC900);
      checkOutput("s1_i_addr_hold", 32'(bus.i_addr), 32'd3);

      // neuron 2 preloaded above threshold fires once
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 2'd2, 24'h001F00, 24'h0);
      setCur(24'h0, 24'h0, 24'h0, 24'h0);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 0);
      checkOutput("s2_spikes", 32'(spike_cnt), 32'd1);
      checkOutput("s2_spike_id", 32'(last_spike_id), 32'd2);
      checkOutput("s2_v2", 32'(dut.u_ram.v_mem[2]), 32'h00FFBF00);
      checkOutput("s2_w2", 32'(dut.u_ram.w_mem[2]), 32'h00000800);
      checkOutput("s2_v0", 32'(dut.u_ram.v_mem[0]), 32'h00FFC000);
      checkOutput("s2_v3", 32'(dut.u_ram.v_mem[3]), 32'h00FFC900);

      // start and cfg_we while busy are both dropped
      setCur(24'h000100, 24'h0, 24'h0, 24'h0);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 5);
      checkOutput("s3_done_count", 32'(done_cnt), 32'd1);
      checkOutput("s3_done_at", 32'(done_at), 32'd13);
      checkOutput("s3_busy_cycles", 32'(busy_cnt), 32'd13);
      checkOutput("s3_v0", 32'(dut.u_ram.v_mem[0]), 32'h00FFC100);
      checkOutput("s3_w0", 32'(dut.u_ram.w_mem[0]), 32'h0);
      checkOutput("s3_w2", 32'(dut.u_ram.w_mem[2]), 32'h00000800);

      // preload and start in the same idle cycle
      setCur(24'h0, 24'h000200, 24'h0, 24'h0);
      runSweep(1'b1, 2'd1, 24'h000500, 24'h000300, 0);
      checkOutput("s4_v1", 32'(dut.u_ram.v_mem[1]), 32'h00000700);
      checkOutput("s4_w1", 32'(dut.u_ram.w_mem[1]), 32'h00000300);
      checkOutput("s4_done_count", 32'(done_cnt), 32'd1);

      // reset during STEP of neuron 1
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h0, 24'h0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         applyStimulus(1'b0, 1'b0, 2'd0, 24'h0, 24'h0);
      end
      checkOutput("mid_step_apply", 32'(bus.core_apply), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("mid_rst_apply", 32'(bus.core_apply), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("mid_rst_v%0d", i), 32'(dut.u_ram.v_mem[i]), 32'h00FFBF00);
      end
      checkOutput("mid_rst_w2", 32'(dut.u_ram.w_mem[2]), 32'h0);
      done_cnt = 0;
      busy_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
         if (bus.busy) busy_cnt++;
      end
      checkOutput("mid_rst_no_done", 32'(done_cnt), 32'd0);
      checkOutput("mid_rst_stays_idle", 32'(busy_cnt), 32'd0);

      // reset beats start and cfg_we in the same cycle
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'd3, 24'h111100, 24'h000100);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'd0, 24'h0, 24'h0);
      checkOutput("prio_v3", 32'(dut.u_ram.v_mem[3]), 32'h00FFBF00);
      checkOutput("prio_w3", 32'(dut.u_ram.w_mem[3]), 32'h0);
      checkOutput("prio_busy", 32'(bus.busy), 32'd0);

`ifdef IZH_SCHED_SPIKE_COUNT_EN
      checkOutput("cnt_after_rst", 32'(spike_count), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         applyStimulus(1'b0, 1'b1, 2'(i), 24'h001F00, 24'h0);
      end
      setCur(24'h0, 24'h0, 24'h0, 24'h0);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 0);
      checkOutput("cnt_sweep1_spikes", 32'(spike_cnt), 32'd4);
      checkOutput("cnt_sweep1", 32'(spike_count), 32'd4);
      checkOutput("cnt_sweep1_w3", 32'(dut.u_ram.w_mem[3]), 32'h00000800);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 0);
      checkOutput("cnt_sweep2_spikes", 32'(spike_cnt), 32'd0);
      checkOutput("cnt_sweep2", 32'(spike_count), 32'd4);
      runSweep(1'b0, 2'd0, 24'h0, 24'h0, 0);
      checkOutput("cnt_sweep3", 32'(spike_count), 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/izhikevich_tdm_scheduler.md
IZHIKEVICH_TDM_SCHEDULER -- requirements
Module: izhikevich_tdm_scheduler

Interface
REQ-001 SHALL have parameter N, default 24, meaning fixed-point word width.
REQ-002 SHALL have parameter Q, default 8, meaning fractional bits.
REQ-003 SHALL have parameter NEURONS, default 8, meaning number of time-multiplexed neurons (power of 2, >=2); AW=$clog2(NEURONS).
REQ-004 SHALL have parameter V_RST, default 24'hFFBF00 (-65.0), meaning voltage reset value of the state RAM.
REQ-005 clk  input  1  sole clock, all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to advance every neuron by one timestep.
REQ-008 busy  output  1  timestep sweep in progress.
REQ-009 done  output  1  one-cycle pulse at sweep end.
REQ-010 cfg_we, cfg_addr, cfg_v, cfg_w  input  1/AW/N/N  state-RAM write port for preload.
REQ-011 i_addr  output  AW  neuron index whose input current is requested.
REQ-012 i_data  input  N  input current; valid exactly one cycle after i_addr.
REQ-013 core_rst, core_apply  output  1/1  drive core rst/apply.
REQ-014 core_v_init, core_w_init, core_i  output  N/N/N  drive core v_init/w_init/i.
REQ-015 core_voltage, core_w, core_is_spiking  input  N/N/1  from core voltage/w/is_spiking.
REQ-016 spike_valid, spike_id  output  1/AW  one-cycle spike event and its neuron index.
REQ-017 spike_count  output  16  total spikes (IZH_SCHED_SPIKE_COUNT_EN only).

Function
REQ-018 SHALL hold per-neuron v and w (N bits each) in an internal NEURONS-deep state RAM.
REQ-019 FSM states: IDLE, LOAD, STEP, WB, DONE.
REQ-020 IDLE: start=1 SHALL set idx=0 and go to LOAD; otherwise stay.
REQ-021 LOAD: core_rst=1, core_v_init=v[idx], core_w_init=w[idx], i_addr=idx; next STEP.
REQ-022 STEP: core_apply=1, core_i=i_data, core_rst=0; next WB.
REQ-023 WB: v[idx]<=core_voltage, w[idx]<=core_w; if core_is_spiking, spike_valid=1, spike_id=idx.
REQ-024 WB: if idx==NEURONS-1 go to DONE, else idx<=idx+1 and go to LOAD; idx SHALL NOT wrap past NEURONS-1.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 busy SHALL be 1 in LOAD, STEP, WB, DONE; 0 in IDLE.
REQ-027 Sweep latency: done asserts exactly 3*NEURONS+1 cycles after the cycle start is sampled.
REQ-028 core_rst and core_apply SHALL never be asserted in the same cycle; both 0 outside LOAD/STEP.
REQ-029 start while busy SHALL be ignored (no queuing).
REQ-030 cfg_we SHALL write v[cfg_addr]/w[cfg_addr] only in IDLE; writes while busy are dropped.
REQ-031 start and cfg_we in the same IDLE cycle: write SHALL land first, sweep sees new value.
REQ-032 i_addr SHALL hold its last value outside LOAD; core_* data outputs don't-care when strobes low.

Reset
REQ-033 rst SHALL return FSM to IDLE from any state, idx=0, including mid-sweep (no done pulse).
REQ-034 rst SHALL set all v to V_RST, all w to 0, busy/done/spike_valid/core_rst/core_apply=0, spike_id=0, i_addr=0, spike_count=0.
REQ-035 rst SHALL take priority over start and cfg_we in the same cycle.

Configuration
REQ-036 Macro IZH_SCHED_SPIKE_COUNT_EN defined: spike_count SHALL increment on each spike_valid, saturating at 16'hFFFF.
REQ-037 Macro undefined: spike_count port and counter SHALL be absent.

Structure
REQ-038 Package izh_sched_pkg SHALL hold the FSM state enum and the V_RST default constant.
REQ-039 State RAM SHALL be a sub-module izh_state_ram (one write port, async read, synchronous reset init).
REQ-040 Scheduler SHALL instantiate neither the core nor the RAM externally; core is instantiated beside it at top level.

Verification (NEURONS=4, core instantiated, v_th=30.0, c=-65.0, d=8.0)
REQ-041 start pulse -> busy high 13 cycles, done at cycle 13, i_addr sequence 0,1,2,3 in LOAD cycles.
REQ-042 cfg v[2]=31.0 (0x001F00), w[2]=0, start -> spike_valid once, spike_id=2, v[2] becomes 0xFFBF00, w[2]=0x000800.
REQ-043 start asserted at cycle 5 of a sweep -> ignored; exactly one done pulse.
REQ-044 rst during STEP of neuron 1 -> next cycle IDLE, busy=0, all v=0xFFBF00, no done.
REQ-045 cfg_we while busy to neuron 0 -> v[0] after sweep equals core result, not cfg_v.
REQ-046 IZH_SCHED_SPIKE_COUNT_EN, all v preloaded to 31.0, 3 sweeps -> spike_count=4 after sweep 1, spikes only where v>v_th thereafter.
